// File: rtl/irom_responder_if.sv
// Fetch-side bus between the PC/fetch stage (master) and the instruction
// memory responder (slave).
//   req_valid/req_ready/req_addr    : fetch request handshake, byte address
//   resp_valid/resp_ready           : response handshake
//   resp_data/resp_addr/resp_err    : instruction word, echoed address, error
interface irom_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_addr, resp_err
    );
endinterface

// File: rtl/irom_responder.sv
// Instruction-memory responder. Accepts word fetches, reads memory on the
// accept edge, delays the result LATENCY-1 stages into a DEPTH-entry
// response FIFO and returns responses in request order. Credits bound the
// outstanding requests so the FIFO cannot overflow; flush drops everything.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request/response handshake (see irom_responder_if)
//   flush           : discard all outstanding requests and responses
//   ld_we/ld_addr/ld_wdata : loader write port (word address)
//   busy            : outstanding request count is nonzero
module irom_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LD_AW     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    irom_responder_if.slave  bus,
    input  logic             flush,
    input  logic             ld_we,
    input  logic [LD_AW-1:0] ld_addr,
    input  logic [31:0]      ld_wdata,
    output logic             busy
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NSTG  = LATENCY - 1;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
    } resp_t;

    logic [31:0] mem [MEM_WORDS];

    logic [CNT_W-1:0] count;
    logic             accept;
    logic             pop;
    logic             addr_err;
    logic [31:0]      rd_data;
    logic             in_valid;
    resp_t            in_ent;
    logic             push_valid;
    resp_t            push_ent;

    resp_t            fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes and credit-based ready
    assign bus.req_ready = (count < CNT_W'(DEPTH)) && !flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.resp_valid && bus.resp_ready;

    // Address check; erroring requests never index the memory
    assign addr_err = (bus.req_addr[1:0] != 2'b00) ||
                      ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));
    assign rd_data  = addr_err ? 32'h0 : mem[bus.req_addr[LD_AW+1:2]];

    assign in_valid    = accept;
    assign in_ent.data = rd_data;
    assign in_ent.addr = bus.req_addr;
    assign in_ent.err  = addr_err;

    // Loader write; request reads on the same edge see the old word
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_wdata;
        end
    end

    // Latency delay stages; the first register captures the memory read
    generate
        if (NSTG > 0) begin : g_pipe
            logic [NSTG-1:0] vld;
            resp_t           ent [NSTG];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld <= '0;
                    for (int i = 0; i < NSTG; i++) begin
                        ent[i] <= '0;
                    end
                end else if (flush) begin
                    vld <= '0;
                end else begin
                    vld[0] <= in_valid;
                    ent[0] <= in_ent;
                    for (int i = 1; i < NSTG; i++) begin
                        vld[i] <= vld[i-1];
                        ent[i] <= ent[i-1];
                    end
                end
            end

            assign push_valid = vld[NSTG-1];
            assign push_ent   = ent[NSTG-1];
        end else begin : g_nopipe
            assign push_valid = in_valid;
            assign push_ent   = in_ent;
        end
    endgenerate

    // Response FIFO; storage is reset so outputs read zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_valid) begin
                fifo_mem[wr_ptr] <= push_ent;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push_valid) - CNT_W'(pop);
        end
    end

    // Outstanding-request credit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.resp_valid = (fifo_cnt != '0);
    assign bus.resp_data  = fifo_mem[rd_ptr].data;
    assign bus.resp_addr  = fifo_mem[rd_ptr].addr;
    assign bus.resp_err   = fifo_mem[rd_ptr].err;
    assign busy           = (count != '0);

endmodule

// File: tb/tb_irom_responder.sv
// Directed bench for irom_responder with default parameters
// (MEM_WORDS=4096, LATENCY=2, DEPTH=4).
module tb_irom_responder;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        busy;

    int vectors;
    int miscompares;

    irom_responder_if bus ();

    irom_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush    (flush),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] d,
                            input logic [31:0] a, input logic e);
        chk1 ({tag, "_valid"}, bus.resp_valid, 1'b1);
        chk32({tag, "_data"},  bus.resp_data,  d);
        chk32({tag, "_addr"},  bus.resp_addr,  a);
        chk1 ({tag, "_err"},   bus.resp_err,   e);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b1;
        flush          = 1'b0;
        ld_we          = 1'b0;
        ld_addr        = '0;
        ld_wdata       = '0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk1 ("rst_valid", bus.resp_valid, 1'b0);
        chk32("rst_data",  bus.resp_data,  32'h0);
        chk32("rst_addr",  bus.resp_addr,  32'h0);
        chk1 ("rst_err",   bus.resp_err,   1'b0);
        chk1 ("rst_busy",  busy,           1'b0);
        #19 rst_n = 1'b1;
        tick();
        chk1("rst_ready", bus.req_ready, 1'b1);

        // Load first four words
        ld_we = 1'b1;
        ld_addr = 12'd0; ld_wdata = 32'h11111111; tick();
        ld_addr = 12'd1; ld_wdata = 32'h22222222; tick();
        ld_addr = 12'd2; ld_wdata = 32'h33333333; tick();
        ld_addr = 12'd3; ld_wdata = 32'h44444444; tick();
        ld_we = 1'b0;

        // 1: back-to-back fetches, no back-pressure
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0; tick();
        chk1("t1_nv0", bus.resp_valid, 1'b0);
        chk1("t1_rdy0", bus.req_ready, 1'b1);
        bus.req_addr = 32'h4; tick();
        chk_resp("t1_r0", 32'h11111111, 32'h0, 1'b0);
        chk1("t1_rdy1", bus.req_ready, 1'b1);
        bus.req_addr = 32'h8; tick();
        chk_resp("t1_r1", 32'h22222222, 32'h4, 1'b0);
        chk1("t1_rdy2", bus.req_ready, 1'b1);
        bus.req_addr = 32'hC; tick();
        chk_resp("t1_r2", 32'h33333333, 32'h8, 1'b0);
        chk1("t1_rdy3", bus.req_ready, 1'b1);
        bus.req_valid = 1'b0; tick();
        chk_resp("t1_r3", 32'h44444444, 32'hC, 1'b0);
        chk1("t1_busy3", busy, 1'b1);
        tick();
        chk1("t1_idle", bus.resp_valid, 1'b0);
        chk1("t1_busy", busy, 1'b0);

        // 2: back-pressure, credits exhaust at DEPTH
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr = 32'h0; tick();
        bus.req_addr = 32'h4; tick();
        bus.req_addr = 32'h8; tick();
        bus.req_addr = 32'hC; tick();
        chk1("t2_full_rdy", bus.req_ready, 1'b0);
        chk1("t2_full_busy", busy, 1'b1);
        bus.req_addr = 32'h0; tick();
        chk1("t2_stall_rdy", bus.req_ready, 1'b0);
        chk_resp("t2_stall", 32'h11111111, 32'h0, 1'b0);
        tick();
        chk_resp("t2_hold", 32'h11111111, 32'h0, 1'b0);
        bus.resp_ready = 1'b1; tick();
        chk_resp("t2_r1", 32'h22222222, 32'h4, 1'b0);
        chk1("t2_rdy_free", bus.req_ready, 1'b1);
        tick();
        chk_resp("t2_r2", 32'h33333333, 32'h8, 1'b0);
        bus.req_addr = 32'h4; tick();
        chk_resp("t2_r3", 32'h44444444, 32'hC, 1'b0);
        bus.req_valid = 1'b0; tick();
        chk_resp("t2_r4", 32'h11111111, 32'h0, 1'b0);
        tick();
        chk_resp("t2_r5", 32'h22222222, 32'h4, 1'b0);
        tick();
        chk1("t2_idle", bus.resp_valid, 1'b0);
        chk1("t2_busy", busy, 1'b0);

        // 3: error responses interleaved with a good fetch
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h6; tick();
        bus.req_addr = 32'hFFFFFFFC; tick();
        chk_resp("t3_mis", 32'h0, 32'h6, 1'b1);
        bus.req_addr = 32'h4; tick();
        chk_resp("t3_top", 32'h0, 32'hFFFFFFFC, 1'b1);
        bus.req_addr = 32'h4000; tick();
        chk_resp("t3_ok", 32'h22222222, 32'h4, 1'b0);
        bus.req_valid = 1'b0; tick();
        chk_resp("t3_oor", 32'h0, 32'h4000, 1'b1);
        tick();
        chk1("t3_idle", bus.resp_valid, 1'b0);

        // 4: flush with three requests outstanding
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr = 32'h0; tick();
        bus.req_addr = 32'h4; tick();
        bus.req_addr = 32'h8; tick();
        bus.req_addr = 32'hC;
        flush = 1'b1;
        #1;
        chk1("t4_flush_rdy", bus.req_ready, 1'b0);
        tick();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        chk1("t4_nv", bus.resp_valid, 1'b0);
        chk1("t4_busy", busy, 1'b0);
        bus.resp_ready = 1'b1; tick();
        chk1("t4_nv2", bus.resp_valid, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8; tick();
        bus.req_valid = 1'b0;
        chk1("t4_lat", bus.resp_valid, 1'b0);
        tick();
        chk_resp("t4_new", 32'h33333333, 32'h8, 1'b0);
        tick();
        chk1("t4_idle", bus.resp_valid, 1'b0);
        chk1("t4_busy2", busy, 1'b0);

        // 6: loader write on the same edge as a fetch of that word
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        ld_we = 1'b1; ld_addr = 12'd2; ld_wdata = 32'hDEADBEEF;
        tick();
        ld_we = 1'b0;
        tick();
        chk_resp("t6_old", 32'h33333333, 32'h8, 1'b0);
        bus.req_valid = 1'b0; tick();
        chk_resp("t6_new", 32'hDEADBEEF, 32'h8, 1'b0);
        tick();
        chk1("t6_idle", bus.resp_valid, 1'b0);

        // 5: asynchronous reset with two buffered responses
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr = 32'h0; tick();
        bus.req_addr = 32'h4; tick();
        bus.req_valid = 1'b0; tick();
        chk_resp("t5_buf", 32'h11111111, 32'h0, 1'b0);
        chk1("t5_busy_pre", busy, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk1 ("t5_rst_valid", bus.resp_valid, 1'b0);
        chk1 ("t5_rst_busy",  busy, 1'b0);
        chk32("t5_rst_data",  bus.resp_data, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        chk1("t5_rdy", bus.req_ready, 1'b1);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0; tick();
        bus.req_valid = 1'b0; tick();
        chk_resp("t5_keep", 32'h11111111, 32'h0, 1'b0);
        tick();
        chk1("t5_idle", bus.resp_valid, 1'b0);
        chk1("t5_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/irom_responder.md
Name: irom_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface; the PC register/fetch stage is the initiator.
- Accepts word fetch requests (byte address), returns instruction word, echoed address and error flag after fixed LATENCY, strictly in request order.
- Buffers responses under back-pressure using credit flow control; supports pipeline flush on redirect.
- Loader write port fills memory from the testbench/boot logic.

Parameters:
MEM_WORDS, 4096, number of 32-bit words; valid byte addresses are 0 .. 4*MEM_WORDS-4
LATENCY, 2, cycles from request accept to earliest resp_valid; legal range 1..4
DEPTH, 4, maximum outstanding requests (in flight plus buffered); must be >= LATENCY for full throughput
LD_AW, 12, loader word-address width; clog2(MEM_WORDS)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept request this cycle
req_addr  input  32  fetch byte address
resp_valid  output  1  response present at head
resp_ready  input  1  consumer takes response this cycle
resp_data  output  32  instruction word, 0 when resp_err
resp_addr  output  32  echo of request address
resp_err  output  1  misaligned or out-of-range request
flush  input  1  discard all outstanding requests and responses
ld_we  input  1  loader write enable
ld_addr  input  LD_AW  loader word address
ld_wdata  input  32  loader write data
busy  output  1  outstanding count nonzero

Behaviour:
- Reset (async, rst_n=0): outstanding count 0, latency pipe invalid, response buffer empty; resp_valid=0, resp_data=0, resp_addr=0, resp_err=0, busy=0. req_ready=1 on first edge after release. Memory contents not reset.
- Accept: req_valid && req_ready at edge t. Memory read synchronous at t. Result travels LATENCY-1 delay stages into the DEPTH-entry response FIFO. resp_valid first seen in cycle t+LATENCY when FIFO empty and no back-pressure.
- Throughput: one request per cycle sustained when resp_ready=1 and DEPTH >= LATENCY.
- Credits: count +1 on accept, -1 on response handshake (resp_valid && resp_ready), unchanged if both in same cycle. req_ready = (count < DEPTH) && !flush. FIFO therefore never overflows; no request is ever dropped except by flush.
- Order: responses strictly in accept order; resp_* stable while resp_valid && !resp_ready.
- Errors: req_addr[1:0] != 0 -> resp_err=1, resp_data=0. req_addr[31:2] >= MEM_WORDS (covers 0xFFFFFFFC reset PC) -> resp_err=1, resp_data=0. No memory access for erroring requests; same latency and ordering as normal requests.
- Flush: cycle with flush=1 -> req_ready=0, no accept. At that edge, pipe entries invalidated, FIFO emptied, count cleared. resp_valid=0 from the next cycle. A response handshake in the flush cycle still completes. Requests accepted from the next cycle onward proceed normally.
- Loader: ld_we writes mem[ld_addr] at edge; allowed anytime, independent of handshake. Same-edge read of the same word returns old data (read-before-write).
- busy = (count != 0).

Test Plan:
1. Load mem[0..3]=0x11111111,0x22222222,0x33333333,0x44444444. Back-to-back requests 0x0,0x4,0x8,0xC from edge t, resp_ready=1, LATENCY=2 -> resp_valid cycles t+2..t+5, data in order, resp_addr echoed, err=0, req_ready stays 1.
2. resp_ready=0, req_valid held with 6 addresses, DEPTH=4 -> exactly 4 accepted, then req_ready=0. Raise resp_ready -> 4 ordered responses; remaining 2 accepted as credits free. No loss or duplicates.
3. Request 0x6 -> resp_err=1, data 0, addr 0x6. Request 0xFFFFFFFC -> err=1. Request 0x4000 with MEM_WORDS=4096 -> err=1. Interleaved valid request 0x4 keeps order.
4. Three requests in flight, flush pulse 1 cycle -> req_ready=0 that cycle, no response from the three, busy=0 next cycle. New request 0x8 -> single response 0x33333333 after LATENCY.
5. Assert rst_n=0 mid-stream with 2 buffered responses -> resp_valid=0 and busy=0 immediately without clock. After release, request 0x0 -> 0x11111111 (memory retained).
6. ld_we to word 2 with 0xDEADBEEF at the same edge as a request to 0x8 -> response 0x33333333. Next request to 0x8 -> 0xDEADBEEF.
